axi2mem_tcdm_rd_if: RTL and testbench

- Sits directly downstream of the AXI read-channel command generator in the axi2mem bridge.
- Accepts paired 32-bit word read commands (lane 0 = low word, lane 1 = high word) on the trans_* interface and issues them to two 32-bit TCDM master ports.
- Collects the TCDM read responses and re-packs them into 64-bit beats with id/last.
- Presents those beats on the data_* handshake that the read channel drains into AXI R.

---
 rtl/axi2mem_tcdm_rd_if.sv | 151 +++++++++++++++
 tb/tb_axi2mem_tcdm_rd_if.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi2mem_tcdm_rd_if.sv
`default_nettype none
// ============================================================================
// Module   : axi2mem_tcdm_rd_if
// Purpose  : Read-side TCDM interface of the axi2mem bridge. Queues paired
//            32-bit word read commands per lane, issues them to two TCDM
//            master ports under response-buffer credit, and re-packs the
//            returned words into 64-bit beats carrying id/last.
// Ports    : clk_i/rst_i          clock, synchronous active-high reset
//            trans_*              per-lane command input (req/gnt handshake)
//            tcdm_*               two 32-bit TCDM master ports (read only)
//            data_*               64-bit beat output (gnt = available, req = pop)
// Revision : 1.0 - initial release
// ============================================================================
module axi2mem_tcdm_rd_if #(
    parameter int unsigned CMD_DEPTH  = 2,
    parameter int unsigned RESP_DEPTH = 4,
    parameter int unsigned ID_WIDTH   = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [1:0]               trans_req_i,
    input  logic [1:0][31:0]         trans_add_i,
    input  logic [1:0][3:0]          trans_be_i,
    input  logic [1:0][ID_WIDTH-1:0] trans_id_i,
    input  logic [1:0]               trans_last_i,
    output logic [1:0]               trans_gnt_o,
    output logic [1:0]               tcdm_req_o,
    output logic [1:0][31:0]         tcdm_add_o,
    output logic [1:0]               tcdm_wen_o,
    output logic [1:0][3:0]          tcdm_be_o,
    output logic [1:0][31:0]         tcdm_wdata_o,
    input  logic [1:0]               tcdm_gnt_i,
    input  logic [1:0]               tcdm_r_valid_i,
    input  logic [1:0][31:0]         tcdm_r_rdata_i,
    output logic [63:0]              data_dat_o,
    output logic [ID_WIDTH-1:0]      data_id_o,
    output logic                     data_last_o,
    output logic                     data_gnt_o,
    input  logic                     data_req_i
);

    localparam int unsigned CAW   = $clog2(CMD_DEPTH);
    localparam int unsigned RAW   = $clog2(RESP_DEPTH);
    localparam int unsigned CMD_W = 32 + 4 + ID_WIDTH + 1;   // {add, be, id, last}
    localparam int unsigned RSP_W = 32 + ID_WIDTH + 1;       // {data, id, last}

    logic [1:0][31:0]         head_data;
    logic [1:0][ID_WIDTH-1:0] head_id;
    logic [1:0]               head_last;
    logic [1:0]               resp_nonempty;
    logic                     data_pop;
    logic                     w_unused;

    assign tcdm_wen_o   = 2'b11;
    assign tcdm_wdata_o = '0;

    assign data_gnt_o  = &resp_nonempty;
    assign data_pop    = data_req_i && data_gnt_o;
    assign data_dat_o  = {head_data[1], head_data[0]};
    assign data_id_o   = head_id[0];
    assign data_last_o = head_last[0];

    // Lane 1 carries its own tag copy; only lane 0's is presented.
    assign w_unused = ^{head_id[1], head_last[1]};

    for (genvar k = 0; k < 2; k++) begin : g_lane
        // Command FIFO
        logic [CMD_W-1:0] cmd_mem_q [CMD_DEPTH];
        logic [CAW-1:0]   cmd_wptr_q, cmd_rptr_q;
        logic [CAW:0]     cmd_cnt_q;
        logic [CMD_W-1:0] cmd_head;
        logic             cmd_push, cmd_pop;

        // Response FIFO
        logic [RSP_W-1:0] rsp_mem_q [RESP_DEPTH];
        logic [RAW-1:0]   rsp_wptr_q, rsp_rptr_q;
        logic [RAW:0]     rsp_cnt_q;
        logic [RSP_W-1:0] rsp_head;
        logic             rsp_push;

        // Outstanding request tracking
        logic [RAW+1:0]      used;
        logic                inflight_q, inflight_d;
        logic [ID_WIDTH-1:0] tag_id_q;
        logic                tag_last_q;

        assign trans_gnt_o[k] = (cmd_cnt_q != (CAW+1)'(CMD_DEPTH));
        assign cmd_push       = trans_req_i[k] && trans_gnt_o[k];
        assign cmd_head       = cmd_mem_q[cmd_rptr_q];

        // Credit: buffered responses plus the one possibly in flight must
        // leave room, so a response landing with a new grant never overflows.
        assign used           = {1'b0, rsp_cnt_q} + (RAW+2)'(inflight_q);
        assign tcdm_req_o[k]  = (cmd_cnt_q != '0) && (used < (RAW+2)'(RESP_DEPTH));
        assign cmd_pop        = tcdm_req_o[k] && tcdm_gnt_i[k];
        assign tcdm_add_o[k]  = cmd_head[CMD_W-1 -: 32];
        assign tcdm_be_o[k]   = cmd_head[ID_WIDTH+1 +: 4];

        // Fixed one-cycle latency: the tag register always matches the
        // response arriving this cycle, and a new grant may refill it.
        assign rsp_push   = tcdm_r_valid_i[k] && inflight_q;
        assign inflight_d = cmd_pop || (inflight_q && !tcdm_r_valid_i[k]);

        assign rsp_head         = rsp_mem_q[rsp_rptr_q];
        assign resp_nonempty[k] = (rsp_cnt_q != '0);
        assign head_data[k]     = rsp_head[RSP_W-1 -: 32];
        assign head_id[k]       = rsp_head[1 +: ID_WIDTH];
        assign head_last[k]     = rsp_head[0];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cmd_wptr_q <= '0;
                cmd_rptr_q <= '0;
                cmd_cnt_q  <= '0;
                rsp_wptr_q <= '0;
                rsp_rptr_q <= '0;
                rsp_cnt_q  <= '0;
                inflight_q <= 1'b0;
                tag_id_q   <= '0;
                tag_last_q <= 1'b0;
            end else begin
                if (cmd_push) cmd_wptr_q <= cmd_wptr_q + CAW'(1);
                if (cmd_pop)  cmd_rptr_q <= cmd_rptr_q + CAW'(1);
                cmd_cnt_q <= cmd_cnt_q + (CAW+1)'(cmd_push) - (CAW+1)'(cmd_pop);

                if (rsp_push) rsp_wptr_q <= rsp_wptr_q + RAW'(1);
                if (data_pop) rsp_rptr_q <= rsp_rptr_q + RAW'(1);
                rsp_cnt_q <= rsp_cnt_q + (RAW+1)'(rsp_push) - (RAW+1)'(data_pop);

                inflight_q <= inflight_d;
                if (cmd_pop) begin
                    tag_id_q   <= cmd_head[1 +: ID_WIDTH];
                    tag_last_q <= cmd_head[0];
                end
            end
        end

        // Storage arrays need no reset: occupancy is governed by the counters.
        always_ff @(posedge clk_i) begin
            if (cmd_push) begin
                cmd_mem_q[cmd_wptr_q] <= {trans_add_i[k], trans_be_i[k],
                                          trans_id_i[k], trans_last_i[k]};
            end
            if (rsp_push) begin
                rsp_mem_q[rsp_wptr_q] <= {tcdm_r_rdata_i[k], tag_id_q, tag_last_q};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi2mem_tcdm_rd_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi2mem_tcdm_rd_if
// Purpose  : Self-checking bench for axi2mem_tcdm_rd_if. Acts as command
//            source, TCDM slave (one-cycle read latency) and beat consumer,
//            and compares every delivered beat with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi2mem_tcdm_rd_if;

    localparam int ID_W = 6;
    localparam int RD   = 4;

    typedef struct packed {
        logic [31:0]     add;
        logic [3:0]      be;
        logic [ID_W-1:0] id;
        logic            last;
    } cmd_t;

    typedef struct packed {
        logic [63:0]     dat;
        logic [ID_W-1:0] id;
        logic            last;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b1;
    logic [1:0]           trans_req_i = '0;
    logic [1:0][31:0]     trans_add_i = '0;
    logic [1:0][3:0]      trans_be_i = '0;
    logic [1:0][ID_W-1:0] trans_id_i = '0;
    logic [1:0]           trans_last_i = '0;
    logic [1:0]           trans_gnt_o;
    logic [1:0]           tcdm_req_o;
    logic [1:0][31:0]     tcdm_add_o;
    logic [1:0]           tcdm_wen_o;
    logic [1:0][3:0]      tcdm_be_o;
    logic [1:0][31:0]     tcdm_wdata_o;
    logic [1:0]           tcdm_gnt_i = '0;
    logic [1:0]           tcdm_r_valid_i = '0;
    logic [1:0][31:0]     tcdm_r_rdata_i = '0;
    logic [63:0]          data_dat_o;
    logic [ID_W-1:0]      data_id_o;
    logic                 data_last_o;
    logic                 data_gnt_o;
    logic                 data_req_i = 1'b0;

    axi2mem_tcdm_rd_if #(.CMD_DEPTH(2), .RESP_DEPTH(RD), .ID_WIDTH(ID_W)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .trans_req_i(trans_req_i), .trans_add_i(trans_add_i), .trans_be_i(trans_be_i),
        .trans_id_i(trans_id_i), .trans_last_i(trans_last_i), .trans_gnt_o(trans_gnt_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o),
        .tcdm_be_o(tcdm_be_o), .tcdm_wdata_o(tcdm_wdata_o), .tcdm_gnt_i(tcdm_gnt_i),
        .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_rdata_i(tcdm_r_rdata_i),
        .data_dat_o(data_dat_o), .data_id_o(data_id_o), .data_last_o(data_last_o),
        .data_gnt_o(data_gnt_o), .data_req_i(data_req_i)
    );

    always #5 clk = ~clk;

    // ---------------- bench state / reference model ----------------
    int    n_asserts = 0;
    int    n_fail    = 0;
    int    cyc       = 0;
    int    n_pops    = 0;
    int    gnt_pct   = 100;
    int    req_pct   = 100;
    int    buf_limit = RD;
    bit    do_rst    = 1'b0;
    cmd_t  pend_q [2][$];       // commands not yet accepted by the DUT
    cmd_t  iss_q  [2][$];       // expected TCDM issue order per lane
    beat_t exp_q  [$];          // expected output beats
    int    pop_cyc [$];
    int    buffered [2];        // responses delivered to DUT minus beats popped
    int    stuck [2];
    logic [1:0]       rv_pend  = '0;
    logic [1:0]       rv_stale = '0;
    logic [1:0][31:0] rv_addr  = '0;
    logic [1:0]       spur     = '0;
    logic [1:0]       hold     = '0;
    logic [1:0][31:0] hold_add = '0;

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hAAAA_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [31:0] a0, input logic [31:0] a1,
                             input logic [ID_W-1:0] id, input logic last);
        cmd_t  c0, c1;
        beat_t b;
        c0 = '{add: a0, be: 4'($urandom_range(1, 15)), id: id, last: last};
        c1 = '{add: a1, be: 4'($urandom_range(1, 15)), id: id, last: last};
        pend_q[0].push_back(c0);
        pend_q[1].push_back(c1);
        iss_q[0].push_back(c0);
        iss_q[1].push_back(c1);
        b = '{dat: {rd_of(a1), rd_of(a0)}, id: id, last: last};
        exp_q.push_back(b);
    endtask

    // One clock cycle: drive inputs at +1, sample and update model at +2.
    task automatic step();
        logic [1:0]       fire;
        logic [1:0][31:0] fadd;
        cmd_t             c;
        beat_t            e;
        @(posedge clk);
        #1;
        cyc++;
        rst_i = do_rst;
        for (int k = 0; k < 2; k++) begin
            trans_req_i[k] = !do_rst && (pend_q[k].size() != 0);
            if (trans_req_i[k]) begin
                c = pend_q[k][0];
                trans_add_i[k]  = c.add;
                trans_be_i[k]   = c.be;
                trans_id_i[k]   = c.id;
                trans_last_i[k] = c.last;
            end
            tcdm_gnt_i[k] = (stuck[k] != 0) ? 1'b0 : ($urandom_range(0, 99) < gnt_pct);
            if (stuck[k] != 0) stuck[k]--;
            tcdm_r_valid_i[k] = rv_pend[k] | spur[k];
            tcdm_r_rdata_i[k] = rv_pend[k] ? rd_of(rv_addr[k]) : $urandom();
        end
        data_req_i = !do_rst && ($urandom_range(0, 99) < req_pct);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (hold[k]) begin
                check($sformatf("req_held_l%0d", k), 64'(tcdm_req_o[k]), 64'd1);
                check($sformatf("add_held_l%0d", k), 64'(tcdm_add_o[k]), 64'(hold_add[k]));
            end
            hold[k]     = !do_rst && tcdm_req_o[k] && !tcdm_gnt_i[k];
            hold_add[k] = tcdm_add_o[k];
            if (trans_req_i[k] && trans_gnt_o[k]) void'(pend_q[k].pop_front());
            fire[k] = tcdm_req_o[k] && tcdm_gnt_i[k];
            fadd[k] = tcdm_add_o[k];
            if (fire[k] && !do_rst) begin
                if (iss_q[k].size() == 0) begin
                    check($sformatf("issue_unexpected_l%0d", k), 64'd1, 64'd0);
                end else begin
                    c = iss_q[k].pop_front();
                    check($sformatf("issue_add_l%0d", k), 64'(tcdm_add_o[k]), 64'(c.add));
                    check($sformatf("issue_be_l%0d", k), 64'(tcdm_be_o[k]), 64'(c.be));
                end
            end
            if (rv_pend[k] && !rv_stale[k]) begin
                buffered[k]++;
                check($sformatf("resp_buffered_l%0d", k), 64'(buffered[k] <= buf_limit), 64'd1);
            end
        end
        if (data_req_i && data_gnt_o) begin
            if (exp_q.size() == 0) begin
                check("beat_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("data_dat", data_dat_o, e.dat);
                check("data_id", 64'(data_id_o), 64'(e.id));
                check("data_last", 64'(data_last_o), 64'(e.last));
            end
            buffered[0]--;
            buffered[1]--;
            n_pops++;
            pop_cyc.push_back(cyc);
        end
        if (do_rst) begin
            exp_q.delete();
            for (int k = 0; k < 2; k++) begin
                pend_q[k].delete();
                iss_q[k].delete();
                buffered[k] = 0;
            end
            hold     = '0;
            rv_stale = fire;
        end else begin
            rv_stale = '0;
        end
        rv_pend = fire;
        rv_addr = fadd;
        spur    = '0;
    endtask

    task automatic run_idle(input int max_cycles);
        int n;
        bit idle;
        n = 0;
        idle = 1'b0;
        while (!idle && n < max_cycles) begin
            step();
            n++;
            idle = (exp_q.size() == 0) && (pend_q[0].size() == 0) &&
                   (pend_q[1].size() == 0) && (rv_pend == 2'b00);
        end
        check("drain_complete", 64'(idle), 64'd1);
    endtask

    task automatic wait_pops(input int target, input int max_cycles);
        int n;
        n = 0;
        while (n_pops < target && n < max_cycles) begin
            step();
            n++;
        end
        check("pop_wait", 64'(n_pops >= target), 64'd1);
    endtask

    initial begin
        int p0;
        stuck[0] = 0; stuck[1] = 0;
        buffered[0] = 0; buffered[1] = 0;

        // Reset
        do_rst = 1'b1;
        step();
        step();
        do_rst = 1'b0;
        step();
        check("rst_trans_gnt", 64'(trans_gnt_o), 64'd3);
        check("rst_tcdm_req", 64'(tcdm_req_o), 64'd0);
        check("rst_data_gnt", 64'(data_gnt_o), 64'd0);
        check("tcdm_wen", 64'(tcdm_wen_o), 64'd3);
        check("tcdm_wdata", 64'(tcdm_wdata_o), 64'd0);

        // 1: single beat, latency N+1 / N+3
        send_beat(32'h100, 32'h104, 6'd5, 1'b1);
        step();
        check("t1_req_n0", 64'(tcdm_req_o), 64'd0);
        step();
        check("t1_req_n1", 64'(tcdm_req_o), 64'd3);
        check("t1_add0", 64'(tcdm_add_o[0]), 64'h100);
        check("t1_add1", 64'(tcdm_add_o[1]), 64'h104);
        step();
        check("t1_gnt_n2", 64'(data_gnt_o), 64'd0);
        p0 = n_pops;
        step();
        check("t1_gnt_n3", 64'(data_gnt_o), 64'd1);
        check("t1_popped", 64'(n_pops), 64'(p0 + 1));
        run_idle(50);

        // 2: lane 1 grant stuck low for 5 cycles
        stuck[1] = 5;
        for (int i = 0; i < 4; i++)
            send_beat(32'h200 + 32'(8 * i), 32'h204 + 32'(8 * i), 6'(i + 1), (i == 3));
        repeat (5) step();
        check("t2_gnt1_full", 64'(trans_gnt_o[1]), 64'd0);
        check("t2_req1_held", 64'(tcdm_req_o[1]), 64'd1);
        check("t2_add1_head", 64'(tcdm_add_o[1]), 64'h204);
        step();
        check("t2_req0_done", 64'(tcdm_req_o[0]), 64'd0);
        check("t2_gnt0", 64'(trans_gnt_o[0]), 64'd1);
        run_idle(100);

        // 3: consumer stalled through an 8-beat burst
        req_pct = 0;
        p0 = n_pops;
        for (int i = 0; i < 8; i++)
            send_beat($urandom() & ~32'h3, $urandom() & ~32'h3, 6'($urandom()), (i == 7));
        repeat (20) step();
        check("t3_req_credit", 64'(tcdm_req_o), 64'd0);
        check("t3_cmd_full", 64'(trans_gnt_o), 64'd0);
        check("t3_data_gnt", 64'(data_gnt_o), 64'd1);
        req_pct = 100;
        run_idle(200);
        check("t3_all_beats", 64'(n_pops - p0), 64'd8);

        // 4: streaming, one beat per cycle with shallow buffering
        buf_limit = 2;
        pop_cyc.delete();
        for (int i = 0; i < 10; i++)
            send_beat($urandom() & ~32'h3, $urandom() & ~32'h3, 6'(i), (i == 9));
        run_idle(100);
        check("t4_beats", 64'(pop_cyc.size()), 64'd10);
        if (pop_cyc.size() == 10)
            check("t4_throughput", 64'(pop_cyc[9] - pop_cyc[0]), 64'd9);
        buf_limit = RD;

        // 5: reset after 2 of 4 beats, stale response afterwards
        p0 = n_pops;
        send_beat(32'h300, 32'h304, 6'd9, 1'b0);
        send_beat(32'h308, 32'h30C, 6'd9, 1'b0);
        wait_pops(p0 + 1, 50);
        send_beat(32'h310, 32'h314, 6'd9, 1'b0);
        send_beat(32'h318, 32'h31C, 6'd9, 1'b1);
        wait_pops(p0 + 2, 50);
        do_rst = 1'b1;
        step();
        do_rst = 1'b0;
        check("t5_stale_pending", 64'(rv_stale != 2'b00), 64'd1);
        step();
        check("t5_trans_gnt", 64'(trans_gnt_o), 64'd3);
        check("t5_data_gnt", 64'(data_gnt_o), 64'd0);
        check("t5_tcdm_req", 64'(tcdm_req_o), 64'd0);
        repeat (4) begin
            step();
            check("t5_no_stale", 64'(data_gnt_o), 64'd0);
        end

        // 6: spurious response with nothing outstanding
        spur[0] = 1'b1;
        step();
        repeat (3) begin
            step();
            check("t6_data_gnt", 64'(data_gnt_o), 64'd0);
        end
        send_beat(32'h400, 32'h404, 6'd17, 1'b1);
        run_idle(50);

        // 7: random grants, random consumer back-pressure
        gnt_pct = 60;
        req_pct = 50;
        p0 = n_pops;
        for (int i = 0; i < 40; i++)
            send_beat($urandom() & ~32'h3, $urandom() & ~32'h3, 6'($urandom()),
                      1'($urandom_range(0, 1)));
        run_idle(3000);
        check("t7_all_beats", 64'(n_pops - p0), 64'd40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
